// File: rtl/vec_alu_pipe.sv
// Two-stage, multi-lane integer vector ALU with predicate mask, scalar broadcast and compare predicate.
// Optional signed saturating ADDS/SUBS (ops 12/13) plus out_sat port when VEC_ALU_SAT_EN is defined.

module vec_alu_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [1:0]       cmp,
  input  logic             en,
`ifdef VEC_ALU_SAT_EN
  output logic             sat,
`endif
  output logic [WIDTH-1:0] res,
  output logic             pred
);
  localparam int SH = $clog2(WIDTH);

  logic [SH-1:0]    sh;
  logic [WIDTH-1:0] sum, diff, r;
  logic             lt_s, lt_u, p;

  assign sh   = b[SH-1:0];
  assign sum  = a + b;
  assign diff = a - b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

`ifdef VEC_ALU_SAT_EN
  logic             ovf_add, ovf_sub;
  logic [WIDTH-1:0] sat_val;
  // Overflow direction always follows the sign of A for both add and subtract.
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign sat     = en && (((op == 4'd12) && ovf_add) || ((op == 4'd13) && ovf_sub));
`endif

  always_comb begin
    r = '0;
    case (op)
      4'd0:  r = sum;
      4'd1:  r = diff;
      4'd2:  r = a * b;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  r = $unsigned($signed(a) >>> sh);
      4'd9:  r = lt_s ? a : b;
      4'd10: r = lt_s ? b : a;
      4'd11: r = b;
`ifdef VEC_ALU_SAT_EN
      4'd12: r = ovf_add ? sat_val : sum;
      4'd13: r = ovf_sub ? sat_val : diff;
`endif
      default: r = '0;
    endcase
  end

  always_comb begin
    p = 1'b0;
    case (cmp)
      2'd0: p = (a == b);
      2'd1: p = (a != b);
      2'd2: p = lt_s;
      2'd3: p = lt_u;
      default: p = 1'b0;
    endcase
  end

  assign res  = en ? r : a;
  assign pred = en & p;
endmodule

module vec_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0]       in_scalar,
  input  logic                   in_scalar_sel,
  input  logic [3:0]             in_op,
  input  logic [1:0]             in_cmp,
  input  logic [LANES-1:0]       in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
`ifdef VEC_ALU_SAT_EN
  output logic [LANES-1:0]       out_sat,
`endif
  output logic [LANES-1:0]       out_pred
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [LANES-1:0][WIDTH-1:0] a;
    logic [LANES-1:0][WIDTH-1:0] b;
    logic [3:0]                  op;
    logic [1:0]                  cmp;
    logic [LANES-1:0]            mask;
  } req_t;

  logic [STAGES:1]             vld_pipe;
  logic                        s1_adv, s2_adv;
  logic [LANES-1:0][WIDTH-1:0] b_mux, res;
  logic [LANES-1:0]            pred;
  req_t                        req, s1;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  for (genvar i = 0; i < LANES; i++) begin : g_bmux
    assign b_mux[i] = in_scalar_sel ? in_scalar : in_b[i*WIDTH +: WIDTH];
  end

  assign req = {in_a, b_mux, in_op, in_cmp, in_mask};

`ifdef VEC_ALU_SAT_EN
  logic [LANES-1:0] sat;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_alu_lane #(.WIDTH(WIDTH)) u_lane (
      .a    (s1.a[i]),
      .b    (s1.b[i]),
      .op   (s1.op),
      .cmp  (s1.cmp),
      .en   (s1.mask[i]),
`ifdef VEC_ALU_SAT_EN
      .sat  (sat[i]),
`endif
      .res  (res[i]),
      .pred (pred[i])
    );
  end

  // Stage 1: operand capture only on an accepted beat so a stall keeps it frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      s1          <= '0;
    end else if (s1_adv) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) s1 <= req;
    end
  end

  // Stage 2: results are registered straight onto the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
      out_result  <= '0;
      out_pred    <= '0;
`ifdef VEC_ALU_SAT_EN
      out_sat     <= '0;
`endif
    end else if (s2_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_result <= res;
        out_pred   <= pred;
`ifdef VEC_ALU_SAT_EN
        out_sat    <= sat;
`endif
      end
    end
  end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// Self-checking bench for vec_alu_pipe (WIDTH=32, LANES=4): directed cases plus a randomized
// stream checked against an arithmetic reference model and an in-order expectation queue.
module tb_vec_alu_pipe;
  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0, reset = 1'b1;
  logic           in_valid = 1'b0, in_ready, in_scalar_sel = 1'b0;
  logic [L*W-1:0] in_a = '0, in_b = '0, out_result;
  logic [W-1:0]   in_scalar = '0;
  logic [3:0]     in_op = '0;
  logic [1:0]     in_cmp = '0;
  logic [L-1:0]   in_mask = '0, out_pred, out_sat;
  logic           out_valid, out_ready = 1'b1;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  vec_alu_pipe #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_scalar(in_scalar), .in_scalar_sel(in_scalar_sel),
    .in_op(in_op), .in_cmp(in_cmp), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
`ifdef VEC_ALU_SAT_EN
    .out_sat(out_sat),
`endif
    .out_pred(out_pred)
  );
`ifndef VEC_ALU_SAT_EN
  assign out_sat = '0;
`endif

  typedef struct {
    logic [L*W-1:0] a, b;
    logic [W-1:0]   s;
    logic           ss;
    logic [3:0]     op;
    logic [1:0]     cmp;
    logic [L-1:0]   mask;
  } beat_t;

  typedef struct {
    logic [L*W-1:0] res;
    logic [L-1:0]   pred, sat;
  } exp_t;

  typedef struct {
    logic           acc, ov, ir;
    logic [L*W-1:0] r;
    logic [L-1:0]   p, s;
  } obs_t;

  function automatic exp_t model(beat_t t);
    exp_t e;
    logic [W-1:0] a, b, r;
    logic [63:0]  prod;
    longint       sx;
    int           sh;
    logic         p, st;
    bit           sat_en;
`ifdef VEC_ALU_SAT_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    for (int i = 0; i < L; i++) begin
      a  = t.a[i*W +: W];
      b  = t.ss ? t.s : t.b[i*W +: W];
      sh = int'(b % W);
      st = 1'b0;
      r  = '0;
      case (t.op)
        0: r = a + b;
        1: r = a - b;
        2: begin prod = {32'b0, a} * {32'b0, b}; r = prod[31:0]; end
        3: r = a & b;
        4: r = a | b;
        5: r = a ^ b;
        6: r = a << sh;
        7: r = a >> sh;
        8: r = $unsigned($signed(a) >>> sh);
        9: r = ($signed(a) < $signed(b)) ? a : b;
        10: r = ($signed(a) > $signed(b)) ? a : b;
        11: r = b;
        12, 13: if (sat_en) begin
          sx = (t.op == 12) ? longint'($signed(a)) + longint'($signed(b))
                            : longint'($signed(a)) - longint'($signed(b));
          if (sx > 64'sd2147483647)       begin r = 32'h7FFFFFFF; st = 1'b1; end
          else if (sx < -64'sd2147483648) begin r = 32'h80000000; st = 1'b1; end
          else r = sx[31:0];
        end
        default: r = '0;
      endcase
      case (t.cmp)
        0: p = (a == b);
        1: p = (a != b);
        2: p = ($signed(a) < $signed(b));
        default: p = (a < b);
      endcase
      if (!t.mask[i]) begin r = a; p = 1'b0; st = 1'b0; end
      e.res[i*W +: W] = r;
      e.pred[i] = p;
      e.sat[i]  = st;
    end
    return e;
  endfunction

  function automatic beat_t rand_beat();
    beat_t t;
    for (int i = 0; i < L; i++) begin
      t.a[i*W +: W] = $urandom;
      t.b[i*W +: W] = ($urandom_range(0, 3) == 0) ? t.a[i*W +: W] : $urandom;
    end
    t.s    = $urandom;
    t.ss   = ($urandom_range(0, 3) == 0);
    t.op   = 4'($urandom_range(0, 15));
    t.cmp  = 2'($urandom_range(0, 3));
    t.mask = 4'($urandom);
    return t;
  endfunction

  task automatic drive(input beat_t t, input logic v);
    in_a = t.a; in_b = t.b; in_scalar = t.s; in_scalar_sel = t.ss;
    in_op = t.op; in_cmp = t.cmp; in_mask = t.mask; in_valid = v;
  endtask

  // One clock: sample handshakes/outputs on the falling edge, then step past the rising edge.
  task automatic cycle(output obs_t o);
    @(negedge clk);
    o.acc = in_valid && in_ready;
    o.ov = out_valid; o.ir = in_ready;
    o.r = out_result; o.p = out_pred; o.s = out_sat;
    @(posedge clk); #1;
  endtask

  task automatic one_beat(input beat_t t, output obs_t o1, output obs_t o2, output obs_t o3);
    drive(t, 1'b1);
    cycle(o1);
    in_valid = 1'b0;
    cycle(o2);
    cycle(o3);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_result !== '0) begin failures++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    checks++; if (out_pred !== '0) begin failures++; $display("FAIL reset_out_pred got=%b want=0", out_pred); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    beat_t t; obs_t o1, o2, o3; exp_t e;
    t = rand_beat();
    t.a = {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}; t.b = {32'd1, 32'd1, 32'd1, 32'd1};
    t.ss = 1'b0; t.op = 4'd0; t.cmp = 2'd0; t.mask = 4'hF;
    e = model(t);
    out_ready = 1'b1;
    one_beat(t, o1, o2, o3);
    checks++; if (o1.acc !== 1'b1) begin failures++; $display("FAIL add_accept got=%b want=1", o1.acc); end
    checks++; if (o2.ov !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%b want=0", o2.ov); end
    checks++; if (o3.ov !== 1'b1) begin failures++; $display("FAIL add_latency got=%b want=1", o3.ov); end
    checks++; if (o3.r !== {32'd0, 32'd4, 32'd3, 32'd2}) begin failures++; $display("FAIL add_result got=%h want=%h", o3.r, {32'd0, 32'd4, 32'd3, 32'd2}); end
    checks++; if (o3.p !== e.pred) begin failures++; $display("FAIL add_pred got=%b want=%b", o3.p, e.pred); end
  endtask

  task automatic test_scalar_broadcast();
    beat_t t; obs_t o1, o2, o3;
    t = rand_beat();
    t.a = {32'd8, 32'd7, 32'd6, 32'd5}; t.ss = 1'b1; t.s = 32'd3;
    t.op = 4'd2; t.mask = 4'hF;
    one_beat(t, o1, o2, o3);
    checks++; if (o3.ov !== 1'b1) begin failures++; $display("FAIL scalar_valid got=%b want=1", o3.ov); end
    checks++; if (o3.r !== {32'd24, 32'd21, 32'd18, 32'd15}) begin failures++; $display("FAIL scalar_result got=%h want=%h", o3.r, {32'd24, 32'd21, 32'd18, 32'd15}); end
  endtask

  task automatic test_masked_cmp();
    beat_t t; obs_t o1, o2, o3; exp_t e;
    t = rand_beat();
    t.a = {32'd9, 32'd0, 32'd4, 32'hFFFFFFFF}; t.b = {32'd2, 32'd1, 32'd4, 32'd0};
    t.ss = 1'b0; t.op = 4'd1; t.cmp = 2'd2; t.mask = 4'b1011;
    e = model(t);
    one_beat(t, o1, o2, o3);
    checks++; if (o3.r !== e.res) begin failures++; $display("FAIL mask_result got=%h want=%h", o3.r, e.res); end
    checks++; if (o3.r[2*W +: W] !== 32'd0) begin failures++; $display("FAIL mask_lane2 got=%h want=0", o3.r[2*W +: W]); end
    checks++; if (o3.p !== 4'b0001) begin failures++; $display("FAIL mask_pred got=%b want=0001", o3.p); end
  endtask

  // mode 0: random valid/ready; mode 1: valid held, out_ready low for cycles 3-6.
  task automatic run_stream(input int n, input int mode);
    exp_t q[$]; exp_t e; beat_t cur; obs_t o;
    int sent = 0, got = 0, cyc = 0;
    logic held = 1'b0;
    logic [L*W-1:0] last_r = '0;
    logic [L-1:0] last_p = '0;
    cur = rand_beat();
    while ((sent < n || q.size() > 0) && cyc < 2000) begin
      cyc++;
      if (mode == 1) out_ready = !(cyc >= 3 && cyc <= 6);
      else           out_ready = ($urandom_range(0, 3) != 0);
      drive(cur, (sent < n) && (mode == 1 || $urandom_range(0, 3) != 0));
      cycle(o);
      if (mode == 1 && cyc == 3) begin
        checks++; if (o.ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", o.ir); end
      end
      if (held) begin
        checks++; if (o.r !== last_r || o.p !== last_p || o.ov !== 1'b1) begin
          failures++; $display("FAIL stall_stable mode=%0d got=%h/%b want=%h/%b", mode, o.r, o.p, last_r, last_p);
        end
      end
      if (o.ov && out_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL stream_extra mode=%0d got=%h want=none", mode, o.r); end
        else begin
          e = q.pop_front(); got++;
          if (o.r !== e.res || o.p !== e.pred || o.s !== e.sat) begin
            failures++; $display("FAIL stream_beat mode=%0d idx=%0d got=%h/%b want=%h/%b", mode, got, o.r, o.p, e.res, e.pred);
          end
        end
      end
      held = o.ov && !out_ready; last_r = o.r; last_p = o.p;
      if (o.acc) begin q.push_back(model(cur)); sent++; cur = rand_beat(); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != n) begin failures++; $display("FAIL stream_count mode=%0d got=%0d want=%0d", mode, got, n); end
  endtask

  task automatic test_back_pressure(); run_stream(6, 1); endtask
  task automatic test_back_to_back(); run_stream(300, 0); endtask

  task automatic test_reset_midstream();
    beat_t t; obs_t o, o1, o2, o3; exp_t e;
    out_ready = 1'b0;
    repeat (2) begin drive(rand_beat(), 1'b1); cycle(o); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b%b want=10", out_valid, in_ready); end
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    checks++; if (out_result !== '0 || out_pred !== '0) begin failures++; $display("FAIL midrst_outputs got=%h/%b want=0", out_result, out_pred); end
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    t = rand_beat(); t.mask = 4'hF;
    e = model(t);
    one_beat(t, o1, o2, o3);
    checks++; if (o2.ov !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b want=0", o2.ov); end
    checks++; if (o3.ov !== 1'b1 || o3.r !== e.res) begin failures++; $display("FAIL midrst_first got=%b/%h want=1/%h", o3.ov, o3.r, e.res); end
  endtask

`ifdef VEC_ALU_SAT_EN
  task automatic test_sat();
    beat_t t; obs_t o1, o2, o3;
    t = rand_beat();
    t.a = {32'd5, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF}; t.b = {32'd1, 32'd1, 32'd1, 32'd1};
    t.ss = 1'b0; t.op = 4'd12; t.mask = 4'b0111;
    one_beat(t, o1, o2, o3);
    checks++; if (o3.r[W-1:0] !== 32'h7FFFFFFF || o3.s !== 4'b0001) begin failures++; $display("FAIL adds_sat got=%h/%b want=7fffffff/0001", o3.r[W-1:0], o3.s); end
    t.a = {32'd5, 32'd5, 32'd0, 32'h80000000}; t.op = 4'd13; t.mask = 4'hF;
    one_beat(t, o1, o2, o3);
    checks++; if (o3.r[W-1:0] !== 32'h80000000 || o3.s !== 4'b0001) begin failures++; $display("FAIL subs_sat got=%h/%b want=80000000/0001", o3.r[W-1:0], o3.s); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_scalar_broadcast();
    test_masked_cmp();
    test_back_pressure();
    test_back_to_back();
    test_reset_midstream();
`ifdef VEC_ALU_SAT_EN
    test_sat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
